// File: rtl/ysyx_25040118_core_seq_if.sv
// IFU/LSU valid-ready request/response bundle driven by the NPC sequencer.
// master = sequencer side, slave = IFU/LSU side.
interface ysyx_25040118_core_seq_if;
   logic ifu_req_valid;
   logic ifu_req_ready;
   logic ifu_rsp_valid;
   logic ifu_rsp_err;
   logic lsu_req_valid;
   logic lsu_req_ready;
   logic lsu_rsp_valid;
   logic lsu_rsp_err;

   modport master (
      output ifu_req_valid, lsu_req_valid,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
   );

   modport slave (
      input  ifu_req_valid, lsu_req_valid,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
   );
endinterface

// File: rtl/ysyx_25040118_core_seq.sv
// Multi-cycle NPC sequencer: fetch -> exec -> optional mem -> writeback, with sticky halt.
// Define NPC_PERF_CNT_EN to add the perf_cycle / perf_instret counter ports.
module ysyx_25040118_core_seq #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic                            clk,
   input  logic                            rst,
   ysyx_25040118_core_seq_if.master        bus,
   output logic                            inst_latch_en,
   input  logic                            is_load,
   input  logic                            is_store,
   input  logic                            ebreak,
   input  logic                            dec_rf_we,
   output logic                            pc_we,
   output logic                            rf_we,
   output logic                            stop,
   output logic [1:0]                      halt_cause,
   output logic [2:0]                      state
`ifdef NPC_PERF_CNT_EN
   ,
   output logic [63:0]                     perf_cycle,
   output logic [63:0]                     perf_instret
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FREQ  = 3'd1,
      FWAIT = 3'd2,
      EXEC  = 3'd3,
      MREQ  = 3'd4,
      MWAIT = 3'd5,
      WB    = 3'd6,
      HALT  = 3'd7
   } seq_state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   seq_state_e      cur, nxt;
   logic [1:0]      cause_nxt;
   logic [TO_W-1:0] to_cnt;
   logic            waiting;
   logic            expired;

   assign waiting = (cur == FREQ) || (cur == FWAIT) || (cur == MREQ) || (cur == MWAIT);
   assign expired = waiting && (to_cnt == TO_LAST);
   assign state   = cur;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur        <= IDLE;
         stop       <= 1'b0;
         halt_cause <= CAUSE_NONE;
      end else begin
         cur <= nxt;
         // stop/halt_cause latch on the entry edge and stay until reset
         if (nxt == HALT && cur != HALT) begin
            stop       <= 1'b1;
            halt_cause <= cause_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)            to_cnt <= '0;
      else if (nxt != cur) to_cnt <= '0;
      else if (waiting)    to_cnt <= to_cnt + 1'b1;
   end

   // Handshakes are tested before expiry so a response on the last cycle still progresses.
   always_comb begin
      nxt       = cur;
      cause_nxt = CAUSE_NONE;
      case (cur)
         IDLE:  nxt = FREQ;
         FREQ: begin
            if (bus.ifu_req_ready) nxt = FWAIT;
            else if (expired) begin nxt = HALT; cause_nxt = CAUSE_TIMEOUT; end
         end
         FWAIT: begin
            if (bus.ifu_rsp_valid) begin
               if (bus.ifu_rsp_err) begin nxt = HALT; cause_nxt = CAUSE_BUSERR; end
               else nxt = EXEC;
            end else if (expired) begin nxt = HALT; cause_nxt = CAUSE_TIMEOUT; end
         end
         EXEC: begin
            if (ebreak) begin nxt = HALT; cause_nxt = CAUSE_EBREAK; end
            else if (is_load || is_store) nxt = MREQ;
            else nxt = WB;
         end
         MREQ: begin
            if (bus.lsu_req_ready) nxt = MWAIT;
            else if (expired) begin nxt = HALT; cause_nxt = CAUSE_TIMEOUT; end
         end
         MWAIT: begin
            if (bus.lsu_rsp_valid) begin
               if (bus.lsu_rsp_err) begin nxt = HALT; cause_nxt = CAUSE_BUSERR; end
               else nxt = WB;
            end else if (expired) begin nxt = HALT; cause_nxt = CAUSE_TIMEOUT; end
         end
         WB:      nxt = FREQ;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ifu_req_valid = (cur == FREQ);
      bus.lsu_req_valid = (cur == MREQ);
      inst_latch_en     = (cur == FWAIT) && bus.ifu_rsp_valid && !bus.ifu_rsp_err;
      pc_we             = (cur == WB);
      rf_we             = (cur == WB) && dec_rf_we;
   end

`ifdef NPC_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_cycle   <= 64'd0;
         perf_instret <= 64'd0;
      end else begin
         if (!stop)          perf_cycle   <= perf_cycle + 64'd1;
         if (cur == WB)      perf_instret <= perf_instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_25040118_core_seq.sv
// Randomized self-checking bench for ysyx_25040118_core_seq (TIMEOUT_CYCLES=8).
// Expected outputs come from per-phase rules and a latency formula per instruction.
module tb_ysyx_25040118_core_seq;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic inst_latch_en, is_load, is_store, ebreak, dec_rf_we;
   logic pc_we, rf_we, stop;
   logic [1:0] halt_cause;
   logic [2:0] state;
`ifdef NPC_PERF_CNT_EN
   logic [63:0] perf_cycle, perf_instret;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int instret_m = 0;
   bit halted_m = 1'b0;
   longint unsigned cyc_run = 0;

   ysyx_25040118_core_seq_if bus();

   ysyx_25040118_core_seq #(.TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .inst_latch_en(inst_latch_en), .is_load(is_load), .is_store(is_store),
      .ebreak(ebreak), .dec_rf_we(dec_rf_we), .pc_we(pc_we), .rf_we(rf_we),
      .stop(stop), .halt_cause(halt_cause), .state(state)
`ifdef NPC_PERF_CNT_EN
      , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
   );

   always #5 clk = ~clk;

   // cycles the core should count as running: rst high and not yet halted
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) cyc_run <= 0;
      else if (!halted_m) cyc_run <= cyc_run + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   function automatic logic [10:0] obs();
      return {state, bus.ifu_req_valid, inst_latch_en, bus.lsu_req_valid, pc_we, rf_we, stop, halt_cause};
   endfunction

   function automatic logic [10:0] ex(input int s, input logic irv, input logic le, input logic lrv,
                                      input logic pw, input logic rw, input logic st, input int hc);
      return {3'(s), irv, le, lrv, pw, rw, st, 2'(hc)};
   endfunction

   // Inputs the DUT must ignore in the current state get random values.
   task automatic junk();
      bus.ifu_req_ready = 1'($urandom);
      bus.ifu_rsp_valid = 1'($urandom);
      bus.ifu_rsp_err   = 1'($urandom);
      bus.lsu_req_ready = 1'($urandom);
      bus.lsu_rsp_valid = 1'($urandom);
      bus.lsu_rsp_err   = 1'($urandom);
      is_load   = 1'($urandom);
      is_store  = 1'($urandom);
      ebreak    = 1'($urandom);
      dec_rf_we = 1'($urandom);
   endtask

   task automatic p_freq(input int rq);
      logic [10:0] e;
      for (int i = 0; i <= rq; i++) begin
         @(negedge clk); junk();
         bus.ifu_req_ready = (i == rq);
         #1 e = ex(1, 1, 0, 0, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL freq cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
   endtask

   task automatic p_fwait(input int rs, input logic err);
      logic [10:0] e;
      for (int i = 0; i <= rs; i++) begin
         @(negedge clk); junk();
         bus.ifu_rsp_valid = (i == rs);
         if (i == rs) bus.ifu_rsp_err = err;
         #1 e = ex(2, 0, (i == rs) && !err, 0, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL fwait cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
   endtask

   task automatic p_exec(input int kind, input logic eb);
      logic [10:0] e;
      @(negedge clk); junk();
      ebreak = eb;
      if (!eb) begin is_load = (kind == 1); is_store = (kind == 2); end
      #1 e = ex(3, 0, 0, 0, 0, 0, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL exec cyc=%0d got=%h exp=%h", cyc, obs(), e); end
      checks++;
   endtask

   task automatic p_mreq(input int mq);
      logic [10:0] e;
      for (int i = 0; i <= mq; i++) begin
         @(negedge clk); junk();
         bus.lsu_req_ready = (i == mq);
         #1 e = ex(4, 0, 0, 1, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL mreq cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
   endtask

   task automatic p_mwait(input int ms, input logic err);
      logic [10:0] e;
      for (int i = 0; i <= ms; i++) begin
         @(negedge clk); junk();
         bus.lsu_rsp_valid = (i == ms);
         if (i == ms) bus.lsu_rsp_err = err;
         #1 e = ex(5, 0, 0, 0, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL mwait cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
   endtask

   task automatic p_wb(input logic rf);
      logic [10:0] e;
      @(negedge clk); junk();
      dec_rf_we = rf;
      #1 e = ex(6, 0, 0, 0, 1, rf, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL wb cyc=%0d got=%h exp=%h", cyc, obs(), e); end
      checks++;
`ifdef NPC_PERF_CNT_EN
      if (perf_instret !== 64'(instret_m)) begin errors++; $display("FAIL instret got=%0d exp=%0d", perf_instret, instret_m); end
      checks++;
      if (perf_cycle !== cyc_run) begin errors++; $display("FAIL perf_cycle got=%0d exp=%0d", perf_cycle, cyc_run); end
      checks++;
`endif
      instret_m++;
   endtask

   task automatic p_halt(input int cause, input int n);
      logic [10:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); junk();
         halted_m = 1'b1;
         #1 e = ex(7, 0, 0, 0, 0, 0, 1, cause);
         if (obs() !== e) begin errors++; $display("FAIL halt cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
`ifdef NPC_PERF_CNT_EN
         if (perf_cycle !== cyc_run) begin errors++; $display("FAIL perf_cycle_halt got=%0d exp=%0d", perf_cycle, cyc_run); end
         checks++;
`endif
      end
   endtask

   task automatic do_reset();
      logic [10:0] e;
      for (int i = 0; i < 2; i++) begin @(negedge clk); junk(); rst = 1'b0; halted_m = 1'b0; end
      @(negedge clk); junk();
      rst = 1'b1;
      instret_m = 0;
      #1 e = ex(0, 0, 0, 0, 0, 0, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs(), e); end
      checks++;
`ifdef NPC_PERF_CNT_EN
      if (perf_cycle !== 64'd0 || perf_instret !== 64'd0) begin
         errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_cycle, perf_instret);
      end
      checks++;
`endif
   endtask

   // kind: 0 alu, 1 load, 2 store. Latency is 4 + stalls, plus 2 + stalls for memory ops.
   task automatic run_instr(input int kind, input logic rf, input int rq, input int rs, input int mq, input int ms);
      int t0, lat;
      t0 = cyc;
      p_freq(rq); p_fwait(rs, 1'b0); p_exec(kind, 1'b0);
      if (kind != 0) begin p_mreq(mq); p_mwait(ms, 1'b0); end
      p_wb(rf);
      lat = 4 + rq + rs + ((kind != 0) ? 2 + mq + ms : 0);
      if (cyc - t0 !== lat) begin errors++; $display("FAIL latency kind=%0d got=%0d exp=%0d", kind, cyc - t0, lat); end
      checks++;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_alu_stream();
      for (int i = 0; i < 5; i++) run_instr(0, 1'b1, 0, 0, 0, 0);
   endtask

   task automatic test_lw_stall();
      run_instr(1, 1'b1, 0, 0, 3, 0);
      run_instr(2, 1'b0, 0, 0, 0, 2);
   endtask

   task automatic test_random();
      int kind;
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 2));
         run_instr(kind, (kind == 2) ? 1'b0 : 1'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      end
   endtask

   task automatic test_ebreak();
      p_freq(0); p_fwait(0, 1'b0); p_exec(0, 1'b1);
      p_halt(1, 4);
      do_reset();
   endtask

   task automatic test_bus_err();
      p_freq(1); p_fwait(1, 1'b1);
      p_halt(2, 3);
      do_reset();
      p_freq(0); p_fwait(0, 1'b0); p_exec(1, 1'b0); p_mreq(1); p_mwait(2, 1'b1);
      p_halt(2, 3);
      do_reset();
   endtask

   task automatic test_timeout();
      logic [10:0] e;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk); junk();
         bus.ifu_req_ready = 1'b0;
         #1 e = ex(1, 1, 0, 0, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL to_freq cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
      p_halt(3, 3);
      do_reset();
      // handshakes landing exactly on the expiry cycle must still advance
      run_instr(1, 1'b1, TO - 1, TO - 1, TO - 1, TO - 1);
      p_freq(0); p_fwait(0, 1'b0); p_exec(2, 1'b0); p_mreq(0);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk); junk();
         bus.lsu_rsp_valid = 1'b0;
         #1 e = ex(5, 0, 0, 0, 0, 0, 0, 0);
         if (obs() !== e) begin errors++; $display("FAIL to_mwait cyc=%0d got=%h exp=%h", cyc, obs(), e); end
         checks++;
      end
      p_halt(3, 2);
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [10:0] e;
      run_instr(0, 1'b1, 0, 0, 0, 0);
      p_freq(0); p_fwait(0, 1'b0); p_exec(1, 1'b0); p_mreq(0); p_mwait(0, 1'b0);
      @(negedge clk); junk();
      rst = 1'b0;
      bus.lsu_rsp_valid = 1'b0;
      @(negedge clk); junk();
      rst = 1'b1;
      instret_m = 0;
      bus.lsu_rsp_valid = 1'b1;
      bus.lsu_rsp_err   = 1'b0;
      #1 e = ex(0, 0, 0, 0, 0, 0, 0, 0);
      if (obs() !== e) begin errors++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, obs(), e); end
      checks++;
`ifdef NPC_PERF_CNT_EN
      if (perf_instret !== 64'd0) begin errors++; $display("FAIL mid_reset_instret got=%0d exp=0", perf_instret); end
      checks++;
`endif
      run_instr(0, 1'b1, 0, 0, 0, 0);
   endtask

   initial begin
      junk();
      test_reset();
      test_alu_stream();
      test_lw_stall();
      test_random();
      test_ebreak();
      test_bus_err();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
